rr_output_arbiter: RTL and testbench

Per-output-port round-robin arbiter and output register for the 5-port NoC router (local, north, south, east, west). It shares one router output port among NUM_IN input sources, each presenting single-flit packets on a valid/ready handshake. Each accepted flit is buffered in a one-entry output register that drives the downstream link. The router instantiates one copy per output direction, after route computation.

---
 rtl/rr_output_arbiter.sv | 100 ++++++++++
 tb/tb_rr_output_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_output_arbiter.sv
// Round-robin arbiter feeding a one-entry output register for one router output port.
// Sources hand over single-flit packets on valid/ready; the register drives the downstream link.
module rr_output_arbiter #(
   parameter int DATA_W = 8,
   parameter int NUM_IN = 5,
   parameter int IDX_W  = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_IN-1:0]        req_valid,
   input  logic [NUM_IN*DATA_W-1:0] req_data,
   output logic [NUM_IN-1:0]        req_ready,
   output logic [DATA_W-1:0]        data_out,
   output logic                     valid_out,
   input  logic                     ready_in,
   output logic [IDX_W-1:0]         grant_idx,
   output logic [15:0]              stall_cnt
);

   logic [DATA_W-1:0] data_q,  data_d;
   logic              valid_q, valid_d;
   logic [IDX_W-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]  ptr_q,   ptr_d;
   logic [15:0]       stall_q, stall_d;

   logic              load_en;
   logic              win_found;
   logic [IDX_W-1:0]  win_idx;
   logic [IDX_W:0]    scan_sum;
   logic [IDX_W-1:0]  scan_idx;

   // The register may take a new flit when empty or when its current flit leaves this cycle.
   assign load_en = !rst && (!valid_q || ready_in);

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_sum  = '0;
      scan_idx  = '0;
      req_ready = '0;
      if (load_en) begin
         for (int k = 0; k < NUM_IN; k++) begin
            scan_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (scan_sum >= (IDX_W+1)'(NUM_IN)) begin
               scan_sum = scan_sum - (IDX_W+1)'(NUM_IN);
            end
            scan_idx = scan_sum[IDX_W-1:0];
            if (!win_found && req_valid[scan_idx]) begin
               win_found = 1'b1;
               win_idx   = scan_idx;
            end
         end
      end
      if (win_found) begin
         req_ready[win_idx] = 1'b1;
      end
   end

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      stall_d = stall_q;
      if (win_found) begin
         data_d  = req_data[win_idx*DATA_W +: DATA_W];
         valid_d = 1'b1;
         grant_d = win_idx;
         ptr_d   = (win_idx == IDX_W'(NUM_IN-1)) ? '0 : win_idx + IDX_W'(1);
      end else if (valid_q && ready_in) begin
         valid_d = 1'b0;
      end
      // Count only cycles where a buffered flit is held back by the downstream.
      if (valid_q && !ready_in && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         grant_q <= '0;
         ptr_q   <= '0;
         stall_q <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         stall_q <= stall_d;
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign grant_idx = grant_q;
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_rr_output_arbiter.sv
// Self-checking bench for rr_output_arbiter: an abstract round-robin model checked every
// falling edge, plus hand-computed directed expectations for each scenario.
module tb_rr_output_arbiter;

   localparam int DATA_W = 8;
   localparam int NUM_IN = 5;
   localparam int IDX_W  = 3;

   logic                     clk = 1'b1;
   logic                     rst = 1'b0;
   logic [NUM_IN-1:0]        req_valid = '0;
   logic [NUM_IN*DATA_W-1:0] req_data;
   logic [NUM_IN-1:0]        req_ready;
   logic [DATA_W-1:0]        data_out;
   logic                     valid_out;
   logic                     ready_in = 1'b0;
   logic [IDX_W-1:0]         grant_idx;
   logic [15:0]              stall_cnt;

   logic [DATA_W-1:0] src_data [NUM_IN];

   int errors = 0;
   int checks = 0;

   // Model state: what the output register and pointer must hold.
   logic [DATA_W-1:0] m_data  = '0;
   logic              m_valid = 1'b0;
   int                m_grant = 0;
   int                m_ptr   = 0;
   int                m_stall = 0;

   rr_output_arbiter #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .IDX_W(IDX_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .data_out  (data_out),
      .valid_out (valid_out),
      .ready_in  (ready_in),
      .grant_idx (grant_idx),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   always_comb begin
      req_data = '0;
      for (int i = 0; i < NUM_IN; i++) req_data[i*DATA_W +: DATA_W] = src_data[i];
   end

   function automatic int pick(input logic [NUM_IN-1:0] v, input int p);
      for (int k = 0; k < NUM_IN; k++) begin
         if (v[(p + k) % NUM_IN]) return (p + k) % NUM_IN;
      end
      return -1;
   endfunction

   function automatic logic [NUM_IN-1:0] expReady();
      logic [NUM_IN-1:0] r;
      int w;
      r = '0;
      if (!rst && (!m_valid || ready_in)) begin
         w = pick(req_valid, m_ptr);
         if (w >= 0) r[w] = 1'b1;
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [NUM_IN-1:0] v, input logic rdy);
      req_valid = v;
      ready_in  = rdy;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk or posedge rst) begin
      int w;
      if (rst) begin
         m_data = '0; m_valid = 1'b0; m_grant = 0; m_ptr = 0; m_stall = 0;
      end else begin
         if (m_valid && !ready_in && m_stall < 65535) m_stall = m_stall + 1;
         w = (!m_valid || ready_in) ? pick(req_valid, m_ptr) : -1;
         if (w >= 0) begin
            m_data  = src_data[w];
            m_valid = 1'b1;
            m_grant = w;
            m_ptr   = (w + 1) % NUM_IN;
         end else if (m_valid && ready_in) begin
            m_valid = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      checkOutput("cyc_req_ready", 32'(req_ready), 32'(expReady()));
      checkOutput("cyc_valid_out", 32'(valid_out), 32'(m_valid));
      checkOutput("cyc_data_out",  32'(data_out),  32'(m_data));
      checkOutput("cyc_grant_idx", 32'(grant_idx), 32'(m_grant));
      checkOutput("cyc_stall_cnt", 32'(stall_cnt), 32'(m_stall));
   end

   initial begin
      logic [IDX_W-1:0] seq [7];
      seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
      for (int i = 0; i < NUM_IN; i++) src_data[i] = 8'hA0 + 8'(i);

      // Reset and a single flit from source 0.
      #1 rst = 1'b1;
      #14 rst = 1'b0;
      src_data[0] = 8'b10_01_1111;
      #1 applyStimulus(5'b00001, 1'b1);
      #1 checkOutput("t1_req_ready", 32'(req_ready), 32'h01);
      nextCycle();
      applyStimulus(5'b00000, 1'b1);
      checkOutput("t1_data_out", 32'(data_out), 32'h9F);
      checkOutput("t1_valid_out", 32'(valid_out), 32'h1);
      checkOutput("t1_grant_idx", 32'(grant_idx), 32'h0);
      nextCycle();
      checkOutput("t1_drained_valid", 32'(valid_out), 32'h0);
      checkOutput("t1_held_data", 32'(data_out), 32'h9F);

      // All five request continuously from a fresh pointer.
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      src_data[0] = 8'hA0;
      applyStimulus(5'b11111, 1'b1);
      for (int i = 0; i < 7; i++) begin
         nextCycle();
         checkOutput("t2_grant_seq", 32'(grant_idx), 32'(seq[i]));
         checkOutput("t2_data_seq", 32'(data_out), 32'(8'hA0 + 8'(seq[i])));
         checkOutput("t2_valid", 32'(valid_out), 32'h1);
      end

      // Pointer wrap: grant 3, then 4 before 0.
      applyStimulus(5'b01000, 1'b1);
      nextCycle();
      checkOutput("t3_grant3", 32'(grant_idx), 32'h3);
      applyStimulus(5'b10001, 1'b1);
      nextCycle();
      checkOutput("t3_grant4_first", 32'(grant_idx), 32'h4);
      nextCycle();
      checkOutput("t3_grant0_second", 32'(grant_idx), 32'h0);

      // Back-pressure with 8'h5A buffered.
      src_data[3] = 8'h5A;
      src_data[1] = 8'h31;
      src_data[2] = 8'h32;
      applyStimulus(5'b01000, 1'b1);
      nextCycle();
      checkOutput("t4_loaded", 32'(data_out), 32'h5A);
      applyStimulus(5'b00110, 1'b0);
      #1 checkOutput("t4_ready_blocked", 32'(req_ready), 32'h0);
      repeat (3) nextCycle();
      checkOutput("t4_data_stable", 32'(data_out), 32'h5A);
      checkOutput("t4_stall_cnt", 32'(stall_cnt), 32'h3);
      checkOutput("t4_req_ready_zero", 32'(req_ready), 32'h0);
      applyStimulus(5'b00110, 1'b1);
      #1 checkOutput("t4_release_ready", 32'(req_ready), 32'h02);
      nextCycle();
      checkOutput("t4_grant1", 32'(grant_idx), 32'h1);
      checkOutput("t4_data1", 32'(data_out), 32'h31);

      // Asynchronous reset between edges while valid_out is high.
      applyStimulus(5'b00000, 1'b1);
      #2 rst = 1'b1;
      #1 checkOutput("t5_valid_rst", 32'(valid_out), 32'h0);
      checkOutput("t5_data_rst", 32'(data_out), 32'h0);
      checkOutput("t5_grant_rst", 32'(grant_idx), 32'h0);
      checkOutput("t5_stall_rst", 32'(stall_cnt), 32'h0);
      applyStimulus(5'b10100, 1'b1);
      #1 checkOutput("t5_ready_in_rst", 32'(req_ready), 32'h0);
      #1 rst = 1'b0;
      #1 checkOutput("t5_first_ready", 32'(req_ready), 32'h04);
      nextCycle();
      checkOutput("t5_first_grant", 32'(grant_idx), 32'h2);

      // Saturating stall counter.
      applyStimulus(5'b00000, 1'b0);
      repeat (65540) nextCycle();
      checkOutput("t6_stall_sat", 32'(stall_cnt), 32'hFFFF);
      checkOutput("t6_valid_held", 32'(valid_out), 32'h1);
      checkOutput("t6_data_held", 32'(data_out), 32'h32);
      applyStimulus(5'b00000, 1'b1);
      nextCycle();
      checkOutput("t6_stall_hold", 32'(stall_cnt), 32'hFFFF);
      checkOutput("t6_drain", 32'(valid_out), 32'h0);

      @(negedge clk);
      #1 $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
